// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide controller: owns HI/LO, computes multiply over a counted
// stall window and sequences an external multi-cycle divider.
module muldiv_ctrl #(
   parameter int DIV_CYCLES = 36,
   parameter int MUL_STAGES = 2
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        ex_valid_i,
   input  logic [2:0]  ex_op_i,
   input  logic [31:0] ex_rs_i,
   input  logic [31:0] ex_rt_i,
   input  logic        flush_i,
   output logic        div_start_o,
   output logic        div_unsigned_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   input  logic [63:0] div_result_i,
   input  logic        div_done_i,
   output logic        stall_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div_timeout_o
);

   // state  | meaning
   // S_IDLE | no operation in flight; accepts MULT/DIV requests and MTHI/MTLO writes
   // S_MUL  | multiply stall window; product written to HI/LO when counter hits 0
   // S_DIV  | divider running with start held high; waits for div_done

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
   localparam int TW = $clog2(DIV_CYCLES + 2);
   localparam logic [MW-1:0] MUL_LOAD = MW'(MUL_STAGES - 1);
   // Terminal count is reached in the (DIV_CYCLES+2)-th DIV cycle.
   localparam logic [TW-1:0] TMO_LOAD = TW'(DIV_CYCLES + 1);

   state_t          state_q, state_d;
   logic [31:0]     op1_q, op1_d;
   logic [31:0]     op2_q, op2_d;
   logic            uns_q, uns_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;
   logic [MW-1:0]   mul_cnt_q, mul_cnt_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            timeout_q, timeout_d;

   logic            is_muldiv;
   logic            req;
   logic            wr_ok;
   logic [63:0]     a_ext;
   logic [63:0]     b_ext;
   logic [63:0]     product;

   assign is_muldiv = (ex_op_i == OP_MULT) || (ex_op_i == OP_MULTU) ||
                      (ex_op_i == OP_DIV)  || (ex_op_i == OP_DIVU);
   assign wr_ok     = ex_valid_i && !flush_i;
   assign req       = wr_ok && is_muldiv;

   // Lower 64 bits of a 64x64 product are correct for both signednesses.
   assign a_ext   = {{32{~uns_q & op1_q[31]}}, op1_q};
   assign b_ext   = {{32{~uns_q & op2_q[31]}}, op2_q};
   assign product = a_ext * b_ext;

   always_comb begin
      state_d   = state_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      uns_d     = uns_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mul_cnt_d = mul_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      timeout_d = timeout_q;
      stall_o   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               stall_o = 1'b1;
               op1_d   = ex_rs_i;
               op2_d   = ex_rt_i;
               uns_d   = (ex_op_i == OP_MULTU) || (ex_op_i == OP_DIVU);
               if ((ex_op_i == OP_MULT) || (ex_op_i == OP_MULTU)) begin
                  state_d   = S_MUL;
                  mul_cnt_d = MUL_LOAD;
               end else begin
                  state_d   = S_DIV;
                  tmo_cnt_d = TMO_LOAD;
               end
            end else if (wr_ok && (ex_op_i == OP_MTHI)) begin
               hi_d = ex_rs_i;
            end else if (wr_ok && (ex_op_i == OP_MTLO)) begin
               lo_d = ex_rs_i;
            end
         end

         S_MUL: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (mul_cnt_q != '0) begin
               stall_o   = 1'b1;
               mul_cnt_d = mul_cnt_q - MW'(1);
            end else begin
               hi_d    = product[63:32];
               lo_d    = product[31:0];
               state_d = S_IDLE;
            end
         end

         S_DIV: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (div_done_i) begin
               hi_d    = div_result_i[63:32];
               lo_d    = div_result_i[31:0];
               state_d = S_IDLE;
            end else begin
               // A hung divider keeps the pipeline frozen; only the flag reports it.
               stall_o = 1'b1;
               if (tmo_cnt_q == '0) begin
                  timeout_d = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q - TW'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         op1_q     <= '0;
         op2_q     <= '0;
         uns_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         mul_cnt_q <= '0;
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         uns_q     <= uns_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         mul_cnt_q <= mul_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Start is a decode of the registered state, so it falls the cycle after completion or flush.
   assign div_start_o    = (state_q == S_DIV);
   assign div_unsigned_o = uns_q;
   assign div_op1_o      = op1_q;
   assign div_op2_o      = op2_q;
   assign hi_o           = hi_q;
   assign lo_o           = lo_q;
   assign div_timeout_o  = timeout_q;

endmodule
